adder_multicycle: RTL and testbench

//   Parametrised multi-cycle add/subtract unit. Processes a WIDTH-bit operation in

---
 rtl/adder_pkg.sv | 18 +
 rtl/adder_multicycle_add_chunk.sv | 25 ++
 rtl/adder_multicycle.sv | 153 +++++++++++++++
 tb/tb_adder_multicycle.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared types and elaboration-time helpers for the multi-cycle
// add/subtract unit.
//   state_t      : FSM encoding (IDLE, BUSY, DONE)
//   chunk_legal(): true when CHUNK is a usable slice width for WIDTH
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // CHUNK must be non-zero and split WIDTH into whole slices.
   function automatic bit chunk_legal(int w, int c);
      return (w >= 1) && (c >= 1) && (c <= w) && ((w % c) == 0);
   endfunction

endpackage

// File: rtl/adder_multicycle_add_chunk.sv
// add_chunk: combinational W-bit ripple slice.
//   a, b, c_in : slice operands and incoming carry
//   sum        : W-bit slice result
//   c_out      : carry out of the slice MSB
//   c_msb      : carry into the slice MSB (feeds signed-overflow detection)
module add_chunk #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   output logic [W-1:0] sum,
   output logic         c_out,
   output logic         c_msb
);

   logic [W:0] full;

   assign full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
   assign sum   = full[W-1:0];
   assign c_out = full[W];
   // sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
   assign c_msb = a[W-1] ^ b[W-1] ^ full[W-1];

endmodule

// File: rtl/adder_multicycle.sv
// adder_multicycle: WIDTH-bit add/subtract done CHUNK bits per clock through a
// single add_chunk slice. Valid/ready on both sides.
//   clk, rst_n        : clock, async active-low reset
//   i_valid / i_ready : operation handshake (a, b, c_in, sub sampled on accept)
//   o_valid / o_ready : result handshake (sum and flags held while o_valid)
//   sum               : result modulo 2^WIDTH
//   c_out             : carry out of MSB (for sub, 1 = no borrow)
//   overflow          : signed overflow
//   zero              : sum == 0
module adder_multicycle
   import adder_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             zero
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

   generate
      if (!chunk_legal(WIDTH, CHUNK)) begin : g_bad_params
         $error("adder_multicycle: CHUNK must divide WIDTH exactly");
      end
   endgenerate

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   // Holds i_ready low until the first edge after reset release.
   logic             init_q;

   logic [CHUNK-1:0] a_sl, b_sl, sl_sum;
   logic             sl_cout, sl_cmsb;

   // Select the active operand slice.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < NUM_CHUNKS; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            a_sl = a_q[i*CHUNK +: CHUNK];
            b_sl = b_q[i*CHUNK +: CHUNK];
         end
      end
   end

   add_chunk #(.W(CHUNK)) u_add_chunk (
      .a     (a_sl),
      .b     (b_sl),
      .c_in  (carry_q),
      .sum   (sl_sum),
      .c_out (sl_cout),
      .c_msb (sl_cmsb)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      unique case (state_q)
         IDLE: begin
            if (i_valid && init_q) begin
               // Subtraction runs as a + ~b + ~c_in.
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? ~c_in : c_in;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
               if (cnt_q == CNT_W'(i)) sum_d[i*CHUNK +: CHUNK] = sl_sum;
            end
            carry_d = sl_cout;
            if (cnt_q == LAST_CNT) begin
               c_out_d = sl_cout;
               ovf_d   = sl_cout ^ sl_cmsb;
               zero_d  = (sum_d == '0);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (o_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         init_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         init_q  <= 1'b1;
      end
   end

   assign i_ready  = (state_q == IDLE) && init_q;
   assign o_valid  = (state_q == DONE);
   assign sum      = sum_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_adder_multicycle.sv
module tb_adder_multicycle;

   localparam int WIDTH      = 32;
   localparam int CHUNK      = 8;
   localparam int NUM_CHUNKS = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             i_valid = 1'b0;
   logic             i_ready;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             c_in = 1'b0;
   logic             sub = 1'b0;
   logic             o_valid;
   logic             o_ready = 1'b0;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             overflow;
   logic             zero;

   int checks = 0;
   int failures = 0;

   // Results captured by run_op
   logic [WIDTH-1:0] r_sum;
   logic             r_cout, r_ovf, r_zero;
   int               r_lat;

   always #5 clk = ~clk;

   adder_multicycle #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_valid  (i_valid),
      .i_ready  (i_ready),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .sub      (sub),
      .o_valid  (o_valid),
      .o_ready  (o_ready),
      .sum      (sum),
      .c_out    (c_out),
      .overflow (overflow),
      .zero     (zero)
   );

   // Issue one operation, wait for its result, capture it, accept it.
   task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input logic ts);
      int n;
      @(negedge clk);
      n = 0;
      while (!i_ready && n < 50) begin @(negedge clk); n++; end
      if (!i_ready) begin
         checks++; failures++;
         $display("FAIL op_issue_timeout i_ready=%0b required 1", i_ready);
      end
      a = ta; b = tb_; c_in = tc; sub = ts; i_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      a = $urandom; b = $urandom; c_in = 1'b1; sub = ~ts;  // must be ignored while busy
      r_lat = 0;
      while (!o_valid && r_lat < 100) begin @(negedge clk); r_lat++; end
      if (!o_valid) begin
         checks++; failures++;
         $display("FAIL op_result_timeout o_valid=%0b required 1", o_valid);
      end
      r_sum = sum; r_cout = c_out; r_ovf = overflow; r_zero = zero;
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({i_ready, o_valid, sum, c_out, overflow, zero} !== '0) begin
         failures++;
         $display("FAIL reset_outputs i_ready=%0b o_valid=%0b sum=%h c=%0b v=%0b z=%0b required all 0",
                  i_ready, o_valid, sum, c_out, overflow, zero);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (i_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_release_ready i_ready=%0b required 0", i_ready);
      end
      @(negedge clk);
      checks++;
      if (i_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_edge_ready i_ready=%0b required 1", i_ready);
      end
   endtask

   task automatic test_add();
      run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      checks++;
      if (r_lat !== NUM_CHUNKS) begin
         failures++;
         $display("FAIL add_latency got %0d required %0d", r_lat, NUM_CHUNKS);
      end
      checks++;
      if ({r_sum, r_cout, r_ovf, r_zero} !== {32'h0, 1'b1, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL add_msb_wrap sum=%h c=%0b v=%0b z=%0b required 00000000 1 1 1",
                  r_sum, r_cout, r_ovf, r_zero);
      end
      run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      checks++;
      if ({r_sum, r_cout, r_ovf, r_zero} !== {32'h0001_0000, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL add_slice_carry sum=%h c=%0b v=%0b z=%0b required 00010000 0 0 0",
                  r_sum, r_cout, r_ovf, r_zero);
      end
      run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
      checks++;
      if ({r_sum, r_cout, r_ovf, r_zero} !== {32'h0, 1'b1, 1'b0, 1'b1}) begin
         failures++;
         $display("FAIL add_carry_in_wrap sum=%h c=%0b v=%0b z=%0b required 00000000 1 0 1",
                  r_sum, r_cout, r_ovf, r_zero);
      end
   endtask

   task automatic test_sub();
      run_op(32'd5, 32'd7, 1'b0, 1'b1);
      checks++;
      if ({r_sum, r_cout, r_ovf, r_zero} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL sub_borrow sum=%h c=%0b v=%0b z=%0b required fffffffe 0 0 0",
                  r_sum, r_cout, r_ovf, r_zero);
      end
      run_op(32'h8000_0000, 32'd1, 1'b0, 1'b1);
      checks++;
      if ({r_sum, r_cout, r_ovf, r_zero} !== {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0}) begin
         failures++;
         $display("FAIL sub_overflow sum=%h c=%0b v=%0b z=%0b required 7fffffff 1 1 0",
                  r_sum, r_cout, r_ovf, r_zero);
      end
      run_op(32'd3, 32'd1, 1'b1, 1'b1);
      checks++;
      if ({r_sum, r_cout, r_ovf, r_zero} !== {32'd1, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL sub_borrow_in sum=%h c=%0b v=%0b z=%0b required 00000001 1 0 0",
                  r_sum, r_cout, r_ovf, r_zero);
      end
   endtask

   task automatic test_backpressure();
      int n;
      @(negedge clk);
      a = 32'd1; b = 32'd1; c_in = 1'b0; sub = 1'b0; i_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < 100) begin @(negedge clk); n++; end
      for (int k = 0; k < 5; k++) begin
         // A second request while the result waits must be dropped.
         if (k == 1) begin
            a = 32'h1234_5678; b = 32'h1111_1111; i_valid = 1'b1;
         end else begin
            i_valid = 1'b0;
         end
         @(negedge clk);
         checks++;
         if ({o_valid, i_ready, sum, c_out, overflow, zero} !== {1'b1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d o_valid=%0b i_ready=%0b sum=%h c=%0b v=%0b z=%0b required 1 0 00000002 0 0 0",
                     k, o_valid, i_ready, sum, c_out, overflow, zero);
         end
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      @(negedge clk);
      o_ready = 1'b0;
      checks++;
      if ({o_valid, i_ready} !== 2'b01) begin
         failures++;
         $display("FAIL bp_release o_valid=%0b i_ready=%0b required 0 1", o_valid, i_ready);
      end
      repeat (NUM_CHUNKS + 3) @(negedge clk);
      checks++;
      if ({o_valid, i_ready} !== 2'b01) begin
         failures++;
         $display("FAIL bp_dropped o_valid=%0b i_ready=%0b required 0 1", o_valid, i_ready);
      end
   endtask

   task automatic test_midop_reset();
      @(negedge clk);
      a = 32'hFFFF_0000; b = 32'h0F0F_0F0F; c_in = 1'b1; sub = 1'b0; i_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({i_ready, o_valid, sum, c_out, overflow, zero} !== '0) begin
         failures++;
         $display("FAIL midop_reset i_ready=%0b o_valid=%0b sum=%h c=%0b v=%0b z=%0b required all 0",
                  i_ready, o_valid, sum, c_out, overflow, zero);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_op(32'd1, 32'd2, 1'b0, 1'b0);
      checks++;
      if ({r_sum, r_cout, r_ovf, r_zero} !== {32'd3, 1'b0, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL post_reset_add sum=%h c=%0b v=%0b z=%0b required 00000003 0 0 0",
                  r_sum, r_cout, r_ovf, r_zero);
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0] ra, rb, bb, es;
      logic             rc, rs, ec, ev, ez;
      logic [WIDTH:0]   full;
      int               shown = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = $urandom; rb = $urandom;
         if (n % 8 == 0) rb = ra;                // exercise zero results on sub
         rc = 1'($urandom_range(0, 1));
         rs = 1'($urandom_range(0, 1));
         bb   = rs ? ~rb : rb;
         full = {1'b0, ra} + {1'b0, bb} + {{WIDTH{1'b0}}, (rs ? ~rc : rc)};
         es   = full[WIDTH-1:0];
         ec   = full[WIDTH];
         ev   = (ra[WIDTH-1] == bb[WIDTH-1]) && (es[WIDTH-1] != ra[WIDTH-1]);
         ez   = (es == '0);
         run_op(ra, rb, rc, rs);
         checks++;
         if ({r_sum, r_cout, r_ovf, r_zero} !== {es, ec, ev, ez}) begin
            failures++;
            if (shown < 10)
               $display("FAIL rand_op a=%h b=%h cin=%0b sub=%0b got %h %0b %0b %0b required %h %0b %0b %0b",
                        ra, rb, rc, rs, r_sum, r_cout, r_ovf, r_zero, es, ec, ev, ez);
            shown++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_backpressure();
      test_midop_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
